// File: rtl/fp32_add_arbiter.sv
// Round-robin front end that shares one 5-stage FP32 adder among NUM_REQ requesters.
// Optional counters: define FP32_ARB_STATS_EN to add stats_clr, issue_cnt and stall_cnt.
module fp32_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_x1,
  input  logic [32*NUM_REQ-1:0]  req_x2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   adder_en,
  output logic [31:0]            adder_x1,
  output logic [31:0]            adder_x2,
  input  logic [31:0]            adder_y,
  output logic                   busy
`ifdef FP32_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [31:0]            issue_cnt,
  output logic [31:0]            stall_cnt
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic               stall;
  logic               any_req;
  logic               hi_found;
  logic [ID_W-1:0]    hi_idx;
  logic [ID_W-1:0]    lo_idx;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [LATENCY];

  assign stall    = rsp_valid & ~rsp_ready;
  assign adder_en = ~stall;

  // Downward scan leaves the lowest requester at or above rr_ptr in hi_idx,
  // and the lowest requester overall in lo_idx for the wrap-around case.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        lo_idx  = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
  end

  assign grant_idx   = hi_found ? hi_idx : lo_idx;
  assign grant_valid = any_req & ~stall & rst_n;

  always_comb begin
    req_ready = '0;
    adder_x1  = '0;
    adder_x2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        adder_x1     = req_x1[32*i +: 32];
        adder_x2     = req_x2[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tags shift in lockstep with the adder stages so the tail tag describes adder_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_id[k] <= '0;
      end
    end else if (adder_en) begin
      tag_valid <= {tag_valid[LATENCY-2:0], grant_valid};
      tag_id[0] <= grant_idx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign rsp_valid = tag_valid[LATENCY-1];
  assign rsp_id    = tag_id[LATENCY-1];
  assign rsp_data  = adder_y;
  assign busy      = |tag_valid;

`ifdef FP32_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else if (stats_clr) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant_valid && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + 32'd1;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed testbench for fp32_add_arbiter with a small 5-stage adder model.
// Define FP32_ARB_STATS_EN to also exercise the statistics counters.
module tb_fp32_add_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_x1;
  logic [127:0] req_x2;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         adder_en;
  logic [31:0]  adder_x1;
  logic [31:0]  adder_x2;
  logic [31:0]  adder_y;
  logic         busy;
`ifdef FP32_ARB_STATS_EN
  logic         stats_clr;
  logic [31:0]  issue_cnt;
  logic [31:0]  stall_cnt;
`endif

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] val [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  // Expected grants and response ids per cycle of the backpressure run.
  logic [3:0]  bp_gnt [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0,
                               4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [1:0]  bp_id  [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                               2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};

  logic [31:0] add_pipe [5];

  fp32_add_arbiter #(.NUM_REQ(4), .ID_W(2), .LATENCY(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .adder_en  (adder_en),
    .adder_x1  (adder_x1),
    .adder_x2  (adder_x2),
    .adder_y   (adder_y),
    .busy      (busy)
`ifdef FP32_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Only the operand pairs used here need exact sums; anything else is a marker value.
  function automatic logic [31:0] addModel(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return a;
    if (a == 32'h0) return b;
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    if (adder_en) begin
      add_pipe[0] <= addModel(adder_x1, adder_x2);
      for (int k = 1; k < 5; k++) add_pipe[k] <= add_pipe[k-1];
    end
  end
  assign adder_y = add_pipe[4];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'h0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    req_x1 = {val[3], val[2], val[1], val[0]};
    req_x2 = '0;
`ifdef FP32_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    applyStimulus(4'hF, 1'b1);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_adder_en", 32'(adder_en), 32'd1);
    @(posedge clk); #1;
    applyStimulus(4'h0, 1'b1);
    rst_n = 1'b1;

    $display("[TB] single request");
    req_x2[31:0] = 32'h40000000;
    for (int c = 0; c < 7; c++) begin
      applyStimulus((c == 0) ? 4'h1 : 4'h0, 1'b1);
      @(negedge clk);
      if (c == 0) begin
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        checkOutput("single_x1", adder_x1, 32'h3F800000);
        checkOutput("single_x2", adder_x2, 32'h40000000);
      end else if (c <= 4) begin
        checkOutput($sformatf("single_early_c%0d", c), 32'(rsp_valid), 32'd0);
      end else if (c == 5) begin
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("single_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("single_rsp_data", rsp_data, 32'h40400000);
        checkOutput("single_busy", 32'(busy), 32'd1);
      end else begin
        checkOutput("single_done_valid", 32'(rsp_valid), 32'd0);
        checkOutput("single_done_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    req_x2 = '0;

    $display("[TB] round robin");
    doReset();
    for (int c = 0; c < 14; c++) begin
      applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b1);
      @(negedge clk);
      if (c < 8) checkOutput($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(4'h1 << (c % 4)));
      if (c >= 5 && c < 13) begin
        checkOutput($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("rr_id_c%0d", c), 32'(rsp_id), 32'((c - 5) % 4));
        checkOutput($sformatf("rr_data_c%0d", c), rsp_data, val[(c - 5) % 4]);
      end else if (c >= 1) begin
        checkOutput($sformatf("rr_idle_c%0d", c), 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
    end

    $display("[TB] backpressure");
    doReset();
    for (int c = 0; c < 16; c++) begin
      applyStimulus((c < 10) ? 4'hF : 4'h0, (c >= 5 && c <= 7) ? 1'b0 : 1'b1);
      @(negedge clk);
      checkOutput($sformatf("bp_grant_c%0d", c), 32'(req_ready), 32'(bp_gnt[c]));
      checkOutput($sformatf("bp_en_c%0d", c), 32'(adder_en), (c >= 5 && c <= 7) ? 32'd0 : 32'd1);
      if (c >= 5 && c <= 14) begin
        checkOutput($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("bp_id_c%0d", c), 32'(rsp_id), 32'(bp_id[c]));
        checkOutput($sformatf("bp_data_c%0d", c), rsp_data, val[bp_id[c]]);
      end else begin
        checkOutput($sformatf("bp_idle_c%0d", c), 32'(rsp_valid), 32'd0);
      end
      if (c >= 5 && c <= 7) checkOutput($sformatf("bp_bubble_c%0d", c), adder_x1, 32'd0);
      @(posedge clk); #1;
    end
`ifdef FP32_ARB_STATS_EN
    @(negedge clk);
    checkOutput("stats_issue", issue_cnt, 32'd7);
    checkOutput("stats_stall", stall_cnt, 32'd3);
    @(posedge clk); #1;
    applyStimulus(4'h1, 1'b1);
    stats_clr = 1'b1;
    @(negedge clk);
    checkOutput("stats_clr_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    stats_clr = 1'b0;
    applyStimulus(4'h0, 1'b1);
    @(negedge clk);
    checkOutput("stats_clr_issue", issue_cnt, 32'd0);
    checkOutput("stats_clr_stall", stall_cnt, 32'd0);
    @(posedge clk); #1;
    applyStimulus(4'h2, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'h0, 1'b1);
    @(negedge clk);
    checkOutput("stats_issue_after", issue_cnt, 32'd1);
    @(posedge clk); #1;
`endif

    $display("[TB] sparse traffic");
    doReset();
    for (int c = 0; c < 13; c++) begin
      applyStimulus((c % 3 == 0 && c <= 6) ? 4'h4 : 4'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("sp_grant_c%0d", c), 32'(req_ready), 32'(req_valid));
      if (c == 5 || c == 8 || c == 11) begin
        checkOutput($sformatf("sp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("sp_id_c%0d", c), 32'(rsp_id), 32'd2);
        checkOutput($sformatf("sp_data_c%0d", c), rsp_data, 32'h40400000);
      end else begin
        checkOutput($sformatf("sp_idle_c%0d", c), 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    applyStimulus(4'h9, 1'b1);
    @(negedge clk);
    checkOutput("sp_rr_ptr3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;

    $display("[TB] reset mid-operation");
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus((c < 3) ? 4'hF : 4'h0, (c < 5) ? 1'b1 : 1'b0);
      @(negedge clk);
      if (c == 5) begin
        checkOutput("mid_valid_before", 32'(rsp_valid), 32'd1);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
      end else begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid_async", 32'(rsp_valid), 32'd0);
    checkOutput("mid_busy_async", 32'(busy), 32'd0);
    checkOutput("mid_en_async", 32'(adder_en), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("mid_stale_c%0d", c), 32'({rsp_valid, busy}), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(4'hA, 1'b1);
    @(negedge clk);
    checkOutput("mid_first_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    applyStimulus(4'h0, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
